aes128_round_ctrl: RTL and testbench

Iterative AES-128 encryption controller that sits directly upstream of the combinational round stage and consumes its outputs. It accepts a plaintext/key pair over a valid/ready handshake and performs the initial AddRoundKey. It then drives the round stage for rounds 1–9, applies the final round (SubBytes, ShiftRows, AddRoundKey; no MixColumns) itself, and presents the ciphertext over a valid/ready handshake.

---
 rtl/aes128_round_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_aes128_round_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encrypt: one round per cycle. AES_ZEROIZE_EN clears state/key after output and blanks ct.
// Latency: 10 cycles accept-to-out_valid; 12-cycle minimum initiation interval.
// Backpressure: in_ready only in IDLE; ct held stable while out_valid && !out_ready.

package aes128_pkg;

  // S-box row-major from 0x00; entry 0 sits in the top byte, hence the ~b index below.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[~b];
  endfunction

  // Byte i = row + 4*col lives at [127-8*i -: 8].
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] s0, s1, s2, s3;
    s0 = w[31:24];
    s1 = w[23:16];
    s2 = w[15:8];
    s3 = w[7:0];
    return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
            xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    logic [7:0] r;
    case (rc)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [3:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
         ^ {rcon(rc), 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// Combinational full AES round (rounds 1..9) plus next round key for round rc.
// Latency: zero, purely combinational.
// Backpressure: none; the controller decides when outputs are captured.
module aes128_round_stage (
  input  logic [3:0]   rc,
  input  logic [127:0] data,
  input  logic [127:0] key_in,
  output logic [127:0] key_out,
  output logic [127:0] rndout
);
  import aes128_pkg::*;

  assign key_out = key_next(key_in, rc);
  assign rndout  = mix_columns(sub_shift(data)) ^ key_out;

endmodule

// Iterative AES-128 controller: initial AddRoundKey, rounds 1..9 via the round stage, own final round.
// Latency: accept on E0, out_valid after E10, handshake no earlier than E11, next accept E12.
// Backpressure: in_ready low outside IDLE; DONE holds ct until out_ready.
module aes128_round_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct,
  output logic         busy
);
  import aes128_pkg::*;

  generate
    if (NUM_ROUNDS != 10) begin : g_cfg_err
      $error("aes128_round_ctrl: NUM_ROUNDS must be 10 for AES-128");
    end
  endgenerate

  localparam logic [3:0] LAST_RC = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [127:0] st;
  logic [127:0] rk;
  logic [3:0]   rc;
  logic [127:0] key_out;
  logic [127:0] rndout;
  logic [127:0] final_st;
  logic         accept;
  logic         out_fire;
  logic         last_rnd;

  aes128_round_stage u_round (
    .rc      (rc),
    .data    (st),
    .key_in  (rk),
    .key_out (key_out),
    .rndout  (rndout)
  );

  assign final_st = sub_shift(st) ^ key_out;
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_rnd = (state == ROUND) && (rc == LAST_RC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)        state_nxt = ROUND;
      ROUND:   if (rc == LAST_RC)   state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:  in_ready = 1'b1;
      ROUND: busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= '0;
      rk <= '0;
      rc <= '0;
    end else if (accept) begin
      st <= pt ^ key;
      rk <= key;
      rc <= 4'd1;
    end else if (state == ROUND) begin
      rk <= key_out;
      if (rc == LAST_RC) begin
        st <= final_st;
      end else begin
        st <= rndout;
        rc <= rc + 4'd1;
      end
    end
`ifdef AES_ZEROIZE_EN
    else if (out_fire) begin
      st <= '0;
      rk <= '0;
    end
`endif
  end

`ifdef AES_ZEROIZE_EN
  // Separate output register so ct stays blank during rounds without gating logic after st.
  logic [127:0] ct_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_q <= '0;
    end else if (last_rnd) begin
      ct_q <= final_st;
    end else if (out_fire) begin
      ct_q <= '0;
    end
  end

  assign ct = ct_q;
`else
  logic unused_ok;
  assign unused_ok = last_rnd ^ out_fire;
  assign ct = st;
`endif

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Directed AES-128 vectors plus handshake, backpressure, back-to-back and reset-abort sequences.
module tb_aes128_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] pt = '0;
  logic [127:0] key = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] ct;
  logic         busy;

  int checks = 0;
  int failures = 0;

  aes128_round_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt        (pt),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ct        (ct),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t tv[4];

  task automatic check128(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_bit(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Called and returns on a falling edge, with out_ready already high.
  task automatic run_vec(input logic [127:0] k, input logic [127:0] p,
                         input logic [127:0] exp, input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_bit({nm, " in_ready before accept"}, in_ready, 1'b1);
    key = k;
    pt = p;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_bit({nm, " busy after accept"}, busy, 1'b1);
`ifdef AES_ZEROIZE_EN
    check128({nm, " ct blank during rounds"}, ct, 128'h0);
`else
    check128({nm, " initial addroundkey"}, ct, k ^ p);
`endif
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_int({nm, " latency"}, n, 10);
    check128({nm, " ct"}, ct, exp);
    @(negedge clk);
    check_bit({nm, " in_ready after handshake"}, in_ready, 1'b1);
    check_bit({nm, " out_valid after handshake"}, out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n_acc;
    int n_out;
    int acc[2];
    logic [127:0] got[2];

    tv[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
              pt:  128'h00112233445566778899aabbccddeeff,
              ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tv[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
              pt:  128'h3243f6a8885a308d313198a2e0370734,
              ct:  128'h3925841d02dc09fbdc118597196a0b32};
    tv[2] = '{key: 128'h0,
              pt:  128'h0,
              ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    tv[3] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
              pt:  128'h6bc1bee22e409f96e93d7e117393172a,
              ct:  128'h3ad77bb40d7a3660a89ecaf32466ef97};

    repeat (2) @(negedge clk);
    check_bit("reset in_ready", in_ready, 1'b1);
    check_bit("reset out_valid", out_valid, 1'b0);
    check_bit("reset busy", busy, 1'b0);
    check128("reset ct", ct, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_vec(tv[i].key, tv[i].pt, tv[i].ct, $sformatf("vec%0d", i));
    end

    // Backpressure: hold out_ready low 5 cycles, try a second request meanwhile.
    out_ready = 1'b0;
    key = tv[1].key;
    pt = tv[1].pt;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_int("bp latency", n, 10);
    for (int j = 0; j < 5; j++) begin
      check128($sformatf("bp ct hold %0d", j), ct, tv[1].ct);
      check_bit($sformatf("bp in_ready %0d", j), in_ready, 1'b0);
      check_bit($sformatf("bp out_valid %0d", j), out_valid, 1'b1);
      if (j == 0) begin
        key = tv[0].key;
        pt = tv[0].pt;
        in_valid = 1'b1;
      end
      @(negedge clk);
    end
    check128("bp ct before release", ct, tv[1].ct);
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_bit("bp out_valid after handshake", out_valid, 1'b0);
    check_bit("bp in_ready after handshake", in_ready, 1'b1);
    @(negedge clk);
    check_bit("bp ignored request not started", busy, 1'b0);

    // Back-to-back with in_valid held high.
    key = tv[0].key;
    pt = tv[0].pt;
    in_valid = 1'b1;
    n_acc = 0;
    n_out = 0;
    acc[0] = 0;
    acc[1] = 0;
    got[0] = '0;
    got[1] = '0;
    for (int i = 0; i < 60 && n_out < 2; i++) begin
      if (n_acc == 1) begin
        key = tv[1].key;
        pt = tv[1].pt;
      end
      if (n_acc == 2) in_valid = 1'b0;
      if (n_acc < 2 && in_valid && in_ready) begin
        acc[n_acc] = i;
        n_acc++;
      end
      if (out_valid) begin
        got[n_out] = ct;
        n_out++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_int("b2b accepts", n_acc, 2);
    check_int("b2b outputs", n_out, 2);
    check_int("b2b initiation interval", acc[1] - acc[0], 12);
    check128("b2b first ct", got[0], tv[0].ct);
    check128("b2b second ct", got[1], tv[1].ct);

    // Reset during round 5, then a clean encryption.
    key = tv[0].key;
    pt = tv[0].pt;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_bit("midreset busy before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("midreset out_valid", out_valid, 1'b0);
    check_bit("midreset in_ready", in_ready, 1'b1);
    check_bit("midreset busy", busy, 1'b0);
    check128("midreset ct", ct, 128'h0);
    repeat (2) @(negedge clk);
    check_bit("midreset held out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(tv[0].key, tv[0].pt, tv[0].ct, "post reset c1");

    repeat (3) @(negedge clk);
`ifdef AES_ZEROIZE_EN
    check128("idle ct zeroized", ct, 128'h0);
    check128("idle st zeroized", dut.st, 128'h0);
    check128("idle rk zeroized", dut.rk, 128'h0);
`else
    check128("idle ct retained", ct, tv[0].ct);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
